// File: rtl/bcd_countdown_timer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bcd_countdown_timer_if
// Brief    : Control pulses and display outputs of the BCD countdown timer.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_countdown_timer_if;
    logic       start;
    logic       clear;
    logic       inc_min;
    logic       inc_sec;
    logic [3:0] mDecimal;
    logic [3:0] mUnit;
    logic [3:0] sDecimal;
    logic [3:0] sUnit;
    logic [2:0] actualState;
    logic       finish;

    modport master (
        output start, clear, inc_min, inc_sec,
        input  mDecimal, mUnit, sDecimal, sUnit, actualState, finish
    );

    modport slave (
        input  start, clear, inc_min, inc_sec,
        output mDecimal, mUnit, sDecimal, sUnit, actualState, finish
    );
endinterface
`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bcd_countdown_timer
// Brief    : mm:ss BCD countdown timer with start/pause/clear and a 1 s
//            prescaler. Optional macro TIMER_AUTO_RELOAD_EN restores the
//            preset time when leaving DONE with start.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000,
    parameter int unsigned MAX_MIN       = 59
) (
    input  logic                 clk_100MHz,
    input  logic                 rst_n,
    bcd_countdown_timer_if.slave tmr_if
);
    localparam int unsigned          c_PRESC_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_TERM = c_PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [6:0]           c_MAX_MIN    = 7'(MAX_MIN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          time_q, time_d;      // {mDecimal, mUnit, sDecimal, sUnit}
    logic [c_PRESC_W-1:0] presc_q, presc_d;
    logic                 finish_q, finish_d;
`ifdef TIMER_AUTO_RELOAD_EN
    logic [15:0]          preset_q, preset_d;
`endif

    logic                 w_tick;
    logic [15:0]          w_time_dec;

    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = t;
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] t,
                                            input logic add_min,
                                            input logic add_sec);
        logic [3:0] m10, m1, s10, s1;
        logic [6:0] min_val;
        {m10, m1, s10, s1} = t;
        min_val = 7'(m10) * 7'd10 + 7'(m1);
        if (add_sec) begin
            if (s10 >= 4'd5 && s1 >= 4'd9) begin
                s10 = 4'd0;
                s1  = 4'd0;
            end else if (s1 >= 4'd9) begin
                s1  = 4'd0;
                s10 = s10 + 4'd1;
            end else begin
                s1 = s1 + 4'd1;
            end
        end
        if (add_min) begin
            if (min_val >= c_MAX_MIN) begin
                m10 = 4'd0;
                m1  = 4'd0;
            end else if (m1 >= 4'd9) begin
                m1  = 4'd0;
                m10 = m10 + 4'd1;
            end else begin
                m1 = m1 + 4'd1;
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    assign w_tick     = (presc_q == c_PRESC_TERM);
    assign w_time_dec = bcd_dec(time_q);

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        presc_d  = presc_q;
`ifdef TIMER_AUTO_RELOAD_EN
        preset_d = preset_q;
`endif
        if (tmr_if.clear) begin
            state_d  = S_IDLE;
            time_d   = 16'h0000;
            presc_d  = '0;
`ifdef TIMER_AUTO_RELOAD_EN
            preset_d = 16'h0000;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    presc_d = '0;
                    if (tmr_if.start) begin
                        if (time_q != 16'h0000) begin
                            state_d  = S_RUN;
`ifdef TIMER_AUTO_RELOAD_EN
                            preset_d = time_q;
`endif
                        end
                    end else begin
                        time_d = bcd_inc(time_q, tmr_if.inc_min, tmr_if.inc_sec);
                    end
                end
                S_RUN: begin
                    // A tick coinciding with start is still applied; reaching zero beats PAUSE.
                    if (w_tick) begin
                        presc_d = '0;
                        time_d  = w_time_dec;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                    if (w_tick && (w_time_dec == 16'h0000)) begin
                        state_d = S_DONE;
                    end else if (tmr_if.start) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (tmr_if.start) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    if (tmr_if.start) begin
                        state_d = S_IDLE;
                        presc_d = '0;
`ifdef TIMER_AUTO_RELOAD_EN
                        time_d  = preset_q;
`else
                        time_d  = 16'h0000;
`endif
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    time_d  = 16'h0000;
                    presc_d = '0;
                end
            endcase
        end
        finish_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            time_q   <= 16'h0000;
            presc_q  <= '0;
            finish_q <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
            preset_q <= 16'h0000;
`endif
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            presc_q  <= presc_d;
            finish_q <= finish_d;
`ifdef TIMER_AUTO_RELOAD_EN
            preset_q <= preset_d;
`endif
        end
    end

    assign tmr_if.mDecimal    = time_q[15:12];
    assign tmr_if.mUnit       = time_q[11:8];
    assign tmr_if.sDecimal    = time_q[7:4];
    assign tmr_if.sUnit       = time_q[3:0];
    assign tmr_if.actualState = state_q;
    assign tmr_if.finish      = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bcd_countdown_timer
// Brief    : Self-checking bench: seconds-level reference model plus directed
//            scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_timer;
    localparam int TPS  = 10;
    localparam int MAXM = 59;

    logic clk_100MHz = 1'b0;
    logic rst_n      = 1'b1;
    int   n_cmp      = 0;
    int   n_fail     = 0;

    bcd_countdown_timer_if tmr_if ();

    bcd_countdown_timer #(
        .TICKS_PER_SEC (TPS),
        .MAX_MIN       (MAXM)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .tmr_if     (tmr_if)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    logic [15:0] dut_time;
    assign dut_time = {tmr_if.mDecimal, tmr_if.mUnit, tmr_if.sDecimal, tmr_if.sUnit};

    // Reference model: plain minutes/seconds integers, state 0..3, run-cycle count
    int m_state, m_min, m_sec, m_cnt, m_pmin, m_psec;

    always @(posedge clk_100MHz or negedge rst_n) begin
        int tot;
        if (!rst_n) begin
            m_state = 0; m_min = 0; m_sec = 0; m_cnt = 0; m_pmin = 0; m_psec = 0;
        end else if (tmr_if.clear) begin
            m_state = 0; m_min = 0; m_sec = 0; m_cnt = 0; m_pmin = 0; m_psec = 0;
        end else begin
            case (m_state)
                0: begin
                    m_cnt = 0;
                    if (tmr_if.start) begin
                        if (m_min * 60 + m_sec != 0) begin
                            m_state = 1; m_pmin = m_min; m_psec = m_sec;
                        end
                    end else begin
                        if (tmr_if.inc_sec) m_sec = (m_sec + 1) % 60;
                        if (tmr_if.inc_min) m_min = (m_min >= MAXM) ? 0 : m_min + 1;
                    end
                end
                1: begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == TPS) begin
                        m_cnt = 0;
                        tot   = m_min * 60 + m_sec - 1;
                        m_min = tot / 60;
                        m_sec = tot % 60;
                        if (tot == 0) m_state = 3;
                    end
                    if (m_state == 1 && tmr_if.start) m_state = 2;
                end
                2: if (tmr_if.start) m_state = 1;
                default: begin
                    if (tmr_if.start) begin
                        m_state = 0;
`ifdef TIMER_AUTO_RELOAD_EN
                        m_min = m_pmin; m_sec = m_psec;
`else
                        m_min = 0; m_sec = 0;
`endif
                    end
                end
            endcase
        end
    end

    function automatic logic [15:0] pack_time(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_100MHz) begin
        chk("model_time",   32'(dut_time),           32'(pack_time(m_min, m_sec)));
        chk("model_state",  32'(tmr_if.actualState), 32'(m_state));
        chk("model_finish", 32'(tmr_if.finish),      32'(m_state == 3));
    end

    task automatic lit(input string name, input logic [15:0] t, input int st, input bit fin);
        chk({name, "_time"},   32'(dut_time),           32'(t));
        chk({name, "_state"},  32'(tmr_if.actualState), 32'(st));
        chk({name, "_finish"}, 32'(tmr_if.finish),      32'(fin));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic pulse(input bit s, input bit c, input bit im, input bit is);
        tmr_if.start = s; tmr_if.clear = c; tmr_if.inc_min = im; tmr_if.inc_sec = is;
        @(negedge clk_100MHz);
        tmr_if.start = 1'b0; tmr_if.clear = 1'b0; tmr_if.inc_min = 1'b0; tmr_if.inc_sec = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] after_done;
        tmr_if.start = 1'b0; tmr_if.clear = 1'b0; tmr_if.inc_min = 1'b0; tmr_if.inc_sec = 1'b0;
        #1 rst_n = 1'b0;
        #2 lit("reset", 16'h0000, 0, 1'b0);
        cyc(2);
        rst_n = 1'b1;

        // Set 01:02 in IDLE
        pulse(0, 0, 1, 0); pulse(0, 0, 0, 1); pulse(0, 0, 0, 1);
        lit("set", 16'h0102, 0, 1'b0);

        // Count down with borrow chain
        pulse(1, 0, 0, 0);              lit("run_entry", 16'h0102, 1, 1'b0);
        cyc(9);                         lit("pre_tick",  16'h0102, 1, 1'b0);
        cyc(1);                         lit("tick1",     16'h0101, 1, 1'b0);
        cyc(10);                        lit("tick2",     16'h0100, 1, 1'b0);
        cyc(10);                        lit("borrow",    16'h0059, 1, 1'b0);

        // Pause retains prescaler
        pulse(0, 1, 0, 0); pulse(0, 0, 0, 1); pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0); cyc(4);
        pulse(1, 0, 0, 0);              lit("pause",      16'h0002, 2, 1'b0);
        cyc(50);                        lit("pause_hold", 16'h0002, 2, 1'b0);
        pulse(1, 0, 0, 0); cyc(4);      lit("resume_pre", 16'h0002, 1, 1'b0);
        cyc(1);                         lit("resume_dec", 16'h0001, 1, 1'b0);

        // Reach DONE from 00:01 and leave with start
        pulse(0, 1, 0, 0); pulse(0, 0, 0, 1); pulse(1, 0, 0, 0);
        cyc(9);                         lit("last_sec", 16'h0001, 1, 1'b0);
        cyc(1);                         lit("done",     16'h0000, 3, 1'b1);
`ifdef TIMER_AUTO_RELOAD_EN
        after_done = 16'h0001;
`else
        after_done = 16'h0000;
`endif
        pulse(1, 0, 0, 0);              lit("done_exit", after_done, 0, 1'b0);

        // Start at zero ignored; wraps of seconds and minutes
        pulse(0, 1, 0, 0); pulse(1, 0, 0, 0);
        lit("start_zero", 16'h0000, 0, 1'b0);
        tmr_if.inc_sec = 1'b1; cyc(59); lit("sec59",    16'h0059, 0, 1'b0);
        cyc(1); tmr_if.inc_sec = 1'b0;  lit("sec_wrap", 16'h0000, 0, 1'b0);
        tmr_if.inc_min = 1'b1; cyc(59); lit("min59",    16'h5900, 0, 1'b0);
        cyc(1); tmr_if.inc_min = 1'b0;  lit("min_wrap", 16'h0000, 0, 1'b0);
        pulse(0, 0, 1, 1);              lit("inc_both", 16'h0101, 0, 1'b0);

        // start coinciding with a tick: decrement then PAUSE, and DONE beats PAUSE
        pulse(0, 1, 0, 0); pulse(0, 0, 0, 1); pulse(0, 0, 0, 1); pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0); cyc(9);
        pulse(1, 0, 0, 0);              lit("tick_pause", 16'h0002, 2, 1'b0);
        pulse(1, 0, 0, 0); cyc(10);     lit("tick_after", 16'h0001, 1, 1'b0);
        cyc(9);
        pulse(1, 0, 0, 0);              lit("done_wins",  16'h0000, 3, 1'b1);
`ifdef TIMER_AUTO_RELOAD_EN
        after_done = 16'h0003;
`else
        after_done = 16'h0000;
`endif
        pulse(1, 0, 0, 0);              lit("done_exit2", after_done, 0, 1'b0);

        // clear beats start and tick
        pulse(0, 1, 0, 0); pulse(0, 0, 0, 1); pulse(1, 0, 0, 0); cyc(9);
        pulse(1, 1, 0, 0);              lit("clear_prio", 16'h0000, 0, 1'b0);

        // Asynchronous reset mid-RUN
        pulse(0, 0, 1, 0); pulse(1, 0, 0, 0); cyc(3);
        lit("pre_reset", 16'h0100, 1, 1'b0);
        #2 rst_n = 1'b0;
        #1 lit("async_rst", 16'h0000, 0, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(12);                        lit("post_rst", 16'h0000, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
